// File: rtl/mips_muldiv_if.sv
// Request/response bundle between the pipeline and the multiply/divide unit.
`timescale 1ns/1ps
interface mips_muldiv_if #(parameter int WIDTH = 32);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             hold;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, src_a, src_b, hold, flush,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, src_a, src_b, hold, flush,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mips_muldiv.sv
// Iterative MIPS HI/LO multiply/divide unit: one radix-2 step per cycle on
// operand magnitudes, followed by a single sign-fixup cycle.
//
// state | meaning
// IDLE  | waiting for start; hi/lo stable
// RUN   | WIDTH shift-add (mul) or restoring shift-subtract (div) steps
// FIX   | sign correction, hi/lo write, done pulse
`timescale 1ns/1ps
module mips_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic clk,
  input  logic rst_n,
  mips_muldiv_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  // op[1] selects divide, op[0] selects unsigned
  logic             in_signed, is_signed, is_div, sign_diff;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum, div_shift;
  logic [WIDTH-1:0] div_diff;
  logic             div_ge;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] q_fix, r_fix;

  // Operand magnitudes, one datapath step, and the sign-corrected results
  always_comb begin
    in_signed = ~bus.op[0];
    a_mag     = (in_signed && bus.src_a[WIDTH-1]) ? (~bus.src_a + 1'b1) : bus.src_a;
    b_mag     = (in_signed && bus.src_b[WIDTH-1]) ? (~bus.src_b + 1'b1) : bus.src_b;

    is_signed = ~op_q[0];
    is_div    = op_q[1];
    sign_diff = is_signed && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);

    // Multiply: {rem, quo} shifts right; rem accumulates the multiplicand
    mul_sum   = {1'b0, rem_q} + {1'b0, (quo_q[0] ? dvs_q : {WIDTH{1'b0}})};

    // Divide: shift the next dividend bit in; the top bit of the shifted
    // value guarantees the subtraction fits even when the low part is smaller
    div_shift = {rem_q, quo_q[WIDTH-1]};
    div_diff  = div_shift[WIDTH-1:0] - dvs_q;
    div_ge    = div_shift[WIDTH] || (div_shift[WIDTH-1:0] >= dvs_q);

    prod      = sign_diff ? (~{rem_q, quo_q} + 1'b1) : {rem_q, quo_q};
    q_fix     = sign_diff ? (~quo_q + 1'b1) : quo_q;
    r_fix     = (is_signed && a_q[WIDTH-1]) ? (~rem_q + 1'b1) : rem_q;
  end

  // Next-state and datapath control; flush overrides hold, hold freezes all
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = done_q;

    if (bus.flush) begin
      state_d = IDLE;
      done_d  = 1'b0;
    end else if (!bus.hold) begin
      done_d = 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_d = RUN;
            cnt_d   = '0;
            op_d    = bus.op;
            a_d     = bus.src_a;
            b_d     = bus.src_b;
            rem_d   = '0;
            quo_d   = a_mag;
            dvs_d   = b_mag;
          end
        end
        RUN: begin
          if (is_div) begin
            rem_d = div_ge ? div_diff : div_shift[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], div_ge};
          end else begin
            rem_d = mul_sum[WIDTH:1];
            quo_d = {mul_sum[0], quo_q[WIDTH-1:1]};
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
        end
        FIX: begin
          if (!is_div) begin
            hi_d = prod[2*WIDTH-1:WIDTH];
            lo_d = prod[WIDTH-1:0];
          end else if (b_q == '0) begin
            hi_d = a_q;
            lo_d = '1;
          end else begin
            hi_d = r_fix;
            lo_d = q_fix;
          end
          done_d  = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  // State, datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule

// File: tb/tb_mips_muldiv.sv
// Bench for mips_muldiv: scoreboard of expected hi/lo pushed at issue and
// popped when done rises, plus latency, flush, hold and reset scenarios.
`timescale 1ns/1ps
module tb_mips_muldiv;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  logic [31:0] exp_hi_q[$];
  logic [31:0] exp_lo_q[$];
  logic [31:0] last_hi = 32'h0;
  logic [31:0] last_lo = 32'h0;

  always #5 clk = ~clk;

  mips_muldiv_if #(.WIDTH(32)) bus();

  mips_muldiv #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] h, output logic [31:0] l);
    longint p;
    h = '0;
    l = '0;
    case (o)
      2'b00: begin p = longint'($signed(a)) * longint'($signed(b)); {h, l} = p; end
      2'b01: begin p = longint'({32'h0, a}) * longint'({32'h0, b}); {h, l} = p; end
      2'b10: begin
        if (b == 32'h0) begin h = a; l = 32'hFFFFFFFF; end
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin h = 32'h0; l = a; end
        else begin l = $signed(a) / $signed(b); h = $signed(a) % $signed(b); end
      end
      default: begin
        if (b == 32'h0) begin h = a; l = 32'hFFFFFFFF; end
        else begin l = a / b; h = a % b; end
      end
    endcase
  endfunction

  // Issue one operation, record its expectation, and count edges until done
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int lat);
    logic [31:0] eh, el;
    @(negedge clk);
    bus.start = 1'b1; bus.op = o; bus.src_a = a; bus.src_b = b;
    model(o, a, b, eh, el);
    exp_hi_q.push_back(eh);
    exp_lo_q.push_back(el);
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = -1;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk); #1;
      if (bus.done) begin lat = n; break; end
    end
  endtask

  task automatic test_reset();
    #1;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", bus.done); end
    total++; if (bus.hi !== 32'h0) begin bad++; $display("FAIL reset_hi got=%h want=0", bus.hi); end
    total++; if (bus.lo !== 32'h0) begin bad++; $display("FAIL reset_lo got=%h want=0", bus.lo); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_vectors();
    logic [1:0]  ops[8] = '{2'b00, 2'b01, 2'b10, 2'b10, 2'b11, 2'b00, 2'b10, 2'b11};
    logic [31:0] as[8]  = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'h80000000,
                            32'h00000064, 32'h80000000, 32'h00000007, 32'hFFFFFFFF};
    logic [31:0] bs[8]  = '{32'h00000005, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF,
                            32'h00000000, 32'h80000000, 32'hFFFFFFFE, 32'h00000010};
    logic [31:0] eh, el, a, b;
    logic [1:0]  o;
    int lat;
    for (int i = 0; i < 20; i++) begin
      if (i < 8) begin o = ops[i]; a = as[i]; b = bs[i]; end
      else begin
        o = 2'($urandom_range(0, 3));
        a = $urandom;
        b = (i % 3 == 0) ? 32'($urandom_range(0, 20)) : $urandom;
        if (i == 9) b = 32'h0;
      end
      run_op(o, a, b, lat);
      eh = exp_hi_q.pop_front();
      el = exp_lo_q.pop_front();
      total++; if (lat !== 33) begin bad++; $display("FAIL vec%0d_latency got=%0d want=33", i, lat); end
      total++; if (bus.hi !== eh) begin bad++; $display("FAIL vec%0d_hi op=%0d a=%h b=%h got=%h want=%h", i, o, a, b, bus.hi, eh); end
      total++; if (bus.lo !== el) begin bad++; $display("FAIL vec%0d_lo op=%0d a=%h b=%h got=%h want=%h", i, o, a, b, bus.lo, el); end
      last_hi = eh; last_lo = el;
    end
  endtask

  task automatic test_flush();
    logic [31:0] eh, el;
    int lat;
    bit seen;
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b01; bus.src_a = 32'h12345678; bus.src_b = 32'h9ABCDEF0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    seen = 0;
    for (int n = 1; n <= 9; n++) begin
      @(posedge clk); #1;
      if (bus.done) seen = 1;
    end
    total++; if (bus.hi !== last_hi || bus.lo !== last_lo) begin bad++;
      $display("FAIL run_hilo_stable got=%h_%h want=%h_%h", bus.hi, bus.lo, last_hi, last_lo); end
    @(negedge clk); bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL flush_busy got=%b want=0", bus.busy); end
    total++; if (bus.done !== 1'b0 || seen) begin bad++; $display("FAIL flush_done got=%b/%0d want=0", bus.done, seen); end
    total++; if (bus.hi !== last_hi || bus.lo !== last_lo) begin bad++;
      $display("FAIL flush_hilo got=%h_%h want=%h_%h", bus.hi, bus.lo, last_hi, last_lo); end
    run_op(2'b01, 32'h0000ABCD, 32'h00001234, lat);
    eh = exp_hi_q.pop_front();
    el = exp_lo_q.pop_front();
    total++; if (lat !== 33) begin bad++; $display("FAIL after_flush_latency got=%0d want=33", lat); end
    total++; if (bus.hi !== eh || bus.lo !== el) begin bad++;
      $display("FAIL after_flush_result got=%h_%h want=%h_%h", bus.hi, bus.lo, eh, el); end
    last_hi = eh; last_lo = el;
    // flush and start together in IDLE: nothing starts
    @(negedge clk); bus.start = 1'b1; bus.flush = 1'b1; bus.op = 2'b00; bus.src_a = 32'h5; bus.src_b = 32'h6;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.flush = 1'b0;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL flush_start_busy got=%b want=0", bus.busy); end
    seen = 0;
    for (int n = 0; n < 40; n++) begin @(posedge clk); #1; if (bus.done) seen = 1; end
    total++; if (seen || bus.lo !== last_lo) begin bad++;
      $display("FAIL flush_start_noop done=%0d lo=%h want_lo=%h", seen, bus.lo, last_lo); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] eh, el;
    int lat;
    bit seen;
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b11; bus.src_a = 32'd1000; bus.src_b = 32'd7;
    model(2'b11, 32'd1000, 32'd7, eh, el);
    exp_hi_q.push_back(eh); exp_lo_q.push_back(el);
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = -1;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      bus.start = (n == 5 || n == 20);
      bus.op = 2'b00; bus.src_a = 32'hFFFFFFFF; bus.src_b = 32'h3;
      @(posedge clk); #1;
      bus.start = 1'b0;
      if (bus.done) begin lat = n; break; end
    end
    eh = exp_hi_q.pop_front();
    el = exp_lo_q.pop_front();
    total++; if (lat !== 33) begin bad++; $display("FAIL busy_start_latency got=%0d want=33", lat); end
    total++; if (bus.hi !== eh || bus.lo !== el) begin bad++;
      $display("FAIL busy_start_result got=%h_%h want=%h_%h", bus.hi, bus.lo, eh, el); end
    last_hi = eh; last_lo = el;
    seen = 0;
    for (int n = 0; n < 40; n++) begin @(posedge clk); #1; if (bus.done || bus.busy) seen = 1; end
    total++; if (seen) begin bad++; $display("FAIL no_queue got=activity want=idle"); end
    // immediate back-to-back: second start at the edge after done
    run_op(2'b10, 32'hFFFFFF00, 32'h00000010, lat);
    eh = exp_hi_q.pop_front(); el = exp_lo_q.pop_front();
    run_op(2'b00, 32'h7FFFFFFF, 32'h7FFFFFFF, lat);
    total++; if (lat !== 33) begin bad++; $display("FAIL b2b_latency got=%0d want=33", lat); end
    eh = exp_hi_q.pop_front(); el = exp_lo_q.pop_front();
    total++; if (bus.hi !== eh || bus.lo !== el) begin bad++;
      $display("FAIL b2b_result got=%h_%h want=%h_%h", bus.hi, bus.lo, eh, el); end
    last_hi = eh; last_lo = el;
  endtask

  task automatic test_hold();
    logic [31:0] eh, el;
    int lat, n, width;
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b00; bus.src_a = 32'hFFFFFFFD; bus.src_b = 32'h00000005;
    model(2'b00, 32'hFFFFFFFD, 32'h00000005, eh, el);
    exp_hi_q.push_back(eh); exp_lo_q.push_back(el);
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = -1;
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      bus.hold = (n >= 5 && n < 10);
      @(posedge clk); n++; #1;
      if (bus.done) begin lat = n; break; end
    end
    total++; if (lat !== 38) begin bad++; $display("FAIL hold_latency got=%0d want=38", lat); end
    width = (lat > 0) ? 1 : 0;
    for (int k = 0; k < 10 && lat > 0; k++) begin
      @(negedge clk);
      bus.hold = (k < 2);
      @(posedge clk); #1;
      if (!bus.done) break;
      width++;
    end
    bus.hold = 1'b0;
    total++; if (width !== 3) begin bad++; $display("FAIL hold_done_width got=%0d want=3", width); end
    eh = exp_hi_q.pop_front(); el = exp_lo_q.pop_front();
    total++; if (bus.hi !== eh || bus.lo !== el) begin bad++;
      $display("FAIL hold_result got=%h_%h want=%h_%h", bus.hi, bus.lo, eh, el); end
    last_hi = eh; last_lo = el;
  endtask

  task automatic test_reset_mid();
    logic [31:0] eh, el;
    int lat;
    bit seen;
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b10; bus.src_a = 32'h00001000; bus.src_b = 32'h00000003;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    #1;
    total++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin bad++;
      $display("FAIL midreset_ctrl got=%b%b want=00", bus.busy, bus.done); end
    total++; if (bus.hi !== 32'h0 || bus.lo !== 32'h0) begin bad++;
      $display("FAIL midreset_hilo got=%h_%h want=0_0", bus.hi, bus.lo); end
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    for (int n = 0; n < 40; n++) begin @(posedge clk); #1; if (bus.done || bus.busy) seen = 1; end
    total++; if (seen) begin bad++; $display("FAIL midreset_no_done got=activity want=idle"); end
    // first start accepted at the first edge after release
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    run_op(2'b11, 32'h00000064, 32'h00000000, lat);
    eh = exp_hi_q.pop_front(); el = exp_lo_q.pop_front();
    total++; if (lat !== 33) begin bad++; $display("FAIL post_reset_latency got=%0d want=33", lat); end
    total++; if (bus.hi !== eh || bus.lo !== el) begin bad++;
      $display("FAIL post_reset_result got=%h_%h want=%h_%h", bus.hi, bus.lo, eh, el); end
  endtask

  initial begin
    bus.start = 1'b0; bus.op = 2'b00; bus.src_a = '0; bus.src_b = '0;
    bus.hold = 1'b0; bus.flush = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_vectors();
    test_flush();
    test_back_to_back();
    test_hold();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
